// File: rtl/cache_array_pkg.sv
// Shared types and sizing helpers for the swept cache line array.
package cache_array_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WB,
        DONE
    } sweep_state_t;

    function automatic int depth_of(input int index_bits);
        return 1 << index_bits;
    endfunction

    function automatic int lanes_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/line_array_sweeper.sv
// Sweep engine: walks every entry, offers dirty lines for writeback,
// then cleans or invalidates them.
module line_array_sweeper
    import cache_array_pkg::*;
#(
    parameter int WIDTH      = 256,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sweep_req_i,
    input  logic                  sweep_inval_i,
    input  logic                  line_valid_i,
    input  logic                  line_dirty_i,
    input  logic [WIDTH-1:0]      line_data_i,
    input  logic                  wb_ready_i,
    output logic [INDEX_BITS-1:0] scan_idx_o,
    output logic                  clr_dirty_o,
    output logic                  clr_valid_o,
    output logic                  busy_o,
    output logic                  wb_valid_o,
    output logic [INDEX_BITS-1:0] wb_index_o,
    output logic [WIDTH-1:0]      wb_data_o,
    output logic                  done_o
);

    sweep_state_t          state_q;
    logic [INDEX_BITS-1:0] ptr_q;
    logic                  inval_q;
    logic                  busy_q;
    logic                  wb_valid_q;
    logic [INDEX_BITS-1:0] wb_index_q;
    logic [WIDTH-1:0]      wb_data_q;
    logic                  done_q;
    logic                  last;
    logic                  needs_wb;

    assign last     = (ptr_q == {INDEX_BITS{1'b1}});
    assign needs_wb = line_valid_i & line_dirty_i;

    // Storage is frozen while busy, so the captured line stays coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            inval_q    <= 1'b0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_index_q <= '0;
            wb_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sweep_req_i) begin
                        state_q <= SCAN;
                        ptr_q   <= '0;
                        inval_q <= sweep_inval_i;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (needs_wb) begin
                        state_q    <= WB;
                        wb_valid_q <= 1'b1;
                        wb_index_q <= ptr_q;
                        wb_data_q  <= line_data_i;
                    end else if (last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                WB: begin
                    if (wb_ready_i) begin
                        wb_valid_q <= 1'b0;
                        wb_index_q <= '0;
                        wb_data_q  <= '0;
                        if (last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SCAN;
                            ptr_q   <= ptr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign scan_idx_o  = ptr_q;
    assign clr_dirty_o = (state_q == WB) && wb_ready_i;
    assign clr_valid_o = inval_q &&
                         (((state_q == SCAN) && !needs_wb) || clr_dirty_o);
    assign busy_o      = busy_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_index_o  = wb_index_q;
    assign wb_data_o   = wb_data_q;
    assign done_o      = done_q;

endmodule

// File: rtl/swept_line_array.sv
// Cache line storage with per-byte writes, valid/dirty tracking and
// a built-in flush/clean sweep engine.
module swept_line_array
    import cache_array_pkg::*;
#(
    parameter int WIDTH      = 256,
    parameter int INDEX_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      write,
    input  logic                      mark_dirty,
    input  logic [INDEX_BITS-1:0]     index,
    input  logic [lanes_of(WIDTH)-1:0] byte_en,
    input  logic [WIDTH-1:0]          datain,
    output logic [WIDTH-1:0]          dataout,
    output logic                      valid_out,
    output logic                      dirty_out,
    input  logic                      sweep_req,
    input  logic                      sweep_inval,
    output logic                      sweep_busy,
    output logic                      wb_valid,
    output logic [INDEX_BITS-1:0]     wb_index,
    output logic [WIDTH-1:0]          wb_data,
    input  logic                      wb_ready,
    output logic                      sweep_done
);

    localparam int DEPTH = depth_of(INDEX_BITS);
    localparam int LANES = lanes_of(WIDTH);

    logic [WIDTH-1:0]      data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      dirty_q;
    logic [WIDTH-1:0]      wr_line;
    logic [INDEX_BITS-1:0] scan_idx;
    logic                  clr_dirty;
    logic                  clr_valid;
    logic                  wr_en;

    assign wr_en = write && !sweep_busy;

    always_comb begin
        wr_line = data_q[index];
        for (int b = 0; b < LANES; b++) begin
            if (byte_en[b]) begin
                wr_line[8*b +: 8] = datain[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (wr_en) begin
                data_q[index]  <= wr_line;
                valid_q[index] <= 1'b1;
                if (mark_dirty) begin
                    dirty_q[index] <= 1'b1;
                end
            end
            if (clr_dirty) begin
                dirty_q[scan_idx] <= 1'b0;
            end
            if (clr_valid) begin
                valid_q[scan_idx] <= 1'b0;
            end
        end
    end

    assign dataout   = data_q[index];
    assign valid_out = valid_q[index];
    assign dirty_out = dirty_q[index];

    line_array_sweeper #(
        .WIDTH      (WIDTH),
        .INDEX_BITS (INDEX_BITS)
    ) u_sweeper (
        .clk           (clk),
        .rst_n         (rst_n),
        .sweep_req_i   (sweep_req),
        .sweep_inval_i (sweep_inval),
        .line_valid_i  (valid_q[scan_idx]),
        .line_dirty_i  (dirty_q[scan_idx]),
        .line_data_i   (data_q[scan_idx]),
        .wb_ready_i    (wb_ready),
        .scan_idx_o    (scan_idx),
        .clr_dirty_o   (clr_dirty),
        .clr_valid_o   (clr_valid),
        .busy_o        (sweep_busy),
        .wb_valid_o    (wb_valid),
        .wb_index_o    (wb_index),
        .wb_data_o     (wb_data),
        .done_o        (sweep_done)
    );

endmodule

// File: doc/swept_line_array.md
Name: swept_line_array

Overview:
- Parametrised cache line storage array: WIDTH-bit data, 2**INDEX_BITS entries, per-entry valid and dirty bits, per-byte write enables.
- Adds a built-in sweep engine that walks every entry, hands dirty lines to the memory-side writeback path over a valid/ready handshake, then cleans or invalidates them.
- Sits inside the L1/L2 cache datapath. It replaces fixed 16-entry data and dirty arrays and gives the cache controller flush and clean support.

Parameters:
- WIDTH, 256, data bits per line; must be a multiple of 8.
- INDEX_BITS, 4, index width; DEPTH = 2**INDEX_BITS entries.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- write  in  1  write strobe for entry at index
- mark_dirty  in  1  with write, set the dirty bit of the entry
- index  in  INDEX_BITS  access index
- byte_en  in  WIDTH/8  byte enables for the write
- datain  in  WIDTH  write data
- dataout  out  WIDTH  combinational data[index]
- valid_out  out  1  combinational valid[index]
- dirty_out  out  1  combinational dirty[index]
- sweep_req  in  1  start a sweep, sampled only in IDLE
- sweep_inval  in  1  captured with sweep_req; 1 = clean and invalidate, 0 = clean only
- sweep_busy  out  1  high whenever the FSM is not IDLE
- wb_valid  out  1  writeback line offered
- wb_index  out  INDEX_BITS  index of the offered line
- wb_data  out  WIDTH  data of the offered line
- wb_ready  in  1  consumer accepts the line
- sweep_done  out  1  one-cycle pulse at the end of a sweep

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - All data, valid and dirty bits clear to 0.
  - FSM goes to IDLE; the sweep pointer and captured inval flag clear.
  - sweep_busy, wb_valid, sweep_done, wb_index and wb_data read 0.
- Reads: dataout, valid_out and dirty_out are combinational from index; zero latency.
- Write (write=1, sweep_busy=0), applied at the clock edge:
  - Each byte b with byte_en[b]=1 takes datain[8b+7:8b]; the other bytes hold.
  - valid is set to 1.
  - dirty is set to 1 if mark_dirty=1. mark_dirty=0 leaves dirty unchanged, so a clean refill over a dirty line is a controller error.
  - byte_en all 0 still sets valid.
- While sweep_busy=1, write is ignored entirely. The controller must stall.
- FSM states:
  - IDLE:
    - sweep_req=1 -> SCAN; ptr=0; inval flag := sweep_inval.
    - A write and sweep_req in the same cycle: the write commits, then the sweep starts.
  - SCAN, at ptr:
    - If valid&dirty -> WB.
    - Otherwise, if the inval flag is set, clear valid[ptr]. Then if ptr==DEPTH-1 -> DONE, else ptr+1.
    - One cycle per clean entry.
  - WB:
    - wb_valid=1, wb_index=ptr, wb_data=data[ptr]. These are registered or held stable until the handshake.
    - On wb_valid&wb_ready: clear dirty[ptr]; clear valid[ptr] if the inval flag is set. Then go to DONE if ptr==DEPTH-1, else SCAN with ptr+1.
    - With wb_ready low, stay in WB indefinitely with the outputs stable.
  - DONE: sweep_done=1 for exactly one cycle -> IDLE.
- sweep_busy=1 in SCAN, WB and DONE.
- Latency: a fully clean array goes from sweep_req to sweep_done in DEPTH+1 cycles. Each dirty line with wb_ready tied high adds 1 cycle.
- ptr is INDEX_BITS wide. Termination is by the ptr==DEPTH-1 compare, never by wrap-around.
- sweep_req while busy is ignored; it is not queued.
- Reset mid-sweep aborts immediately; all state clears and no sweep_done pulse is issued.
- wb_ready while wb_valid=0 has no effect.

Decomposition:
- Shared package cache_array_pkg:
  - typedef enum sweep_state_t {IDLE, SCAN, WB, DONE}.
  - Helper localparam function for DEPTH and byte-lane count.
- One sub-module: line_array_sweeper.
  - Contains the FSM, ptr, inval flag and handshake.
  - Drives clear-dirty, clear-valid and the scan index into the storage.
- The top holds the storage and the byte-enable merge.

Test Plan:
- Reset, then read all 16 indices -> dataout=0, valid_out=0, dirty_out=0 everywhere; sweep_busy=0.
- Write index 3, datain=all 0xAA, byte_en all 1. Then write index 3, datain=all 0x55, byte_en=0x0000_0001 -> dataout byte0=0x55, bytes1..31=0xAA, valid_out=1, dirty_out=0.
- Dirty writes at indices 2 and 9; sweep_req=1, sweep_inval=0; wb_ready=1 -> wb_valid pulses with wb_index=2 then 9 and correct data; sweep_done 19 cycles after req; afterwards dirty=0 and valid=1 at both.
- Same setup with sweep_inval=1 and wb_ready held low 5 cycles at index 2 -> wb_index and wb_data stable for the stall; after done, valid=0 everywhere.
- A write issued while sweep_busy=1 -> the array is unchanged. sweep_req while busy -> no second sweep. Index 15 dirty -> last handshake leads directly to DONE.
- rst_n asserted during WB at index 9 -> wb_valid drops at once, all entries read 0, no sweep_done pulse; a new sweep on a clean array completes in 17 cycles.
